serializer_stream: RTL and testbench
====================================

Name: serializer_stream

Overview:
Parametrised successor to the TX parallel-to-serial stage of the PCIe PHY transmit path. It sits directly after the 8b10b encoder and accepts WIDTH-bit symbols over a valid/ready handshake. A one-entry holding buffer feeds a shift register, so consecutive symbols go out back-to-back with no gap bit. It drives a defined idle level instead of high impedance, flags the first bit of each symbol, and reports underrun.

Parameters:
WIDTH, 10, symbol width in bits (min 2).
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = bit 0 first.
IDLE_VAL, 1'b0, value driven on out_bit while out_valid = 0.

Ports:
clk  input  1  rising-edge clock; one serial bit per cycle.
reset  input  1  synchronous, active-high reset.
in_data  input  WIDTH  parallel symbol from the encoder.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block accepts in_data this cycle.
out_bit  output  1  serial data, registered.
out_valid  output  1  out_bit carries a symbol bit, registered.
out_sof  output  1  out_bit is the first bit of a symbol, registered.
underrun  output  1  one-cycle pulse: the stream stopped because no symbol was ready.

Behaviour:
- Reset (sampled on clk while reset = 1):
  - hold_full = 0, shifter empty, bit counter = 0.
  - out_bit = IDLE_VAL, out_valid = 0, out_sof = 0, underrun = 0.
  - in_ready is forced to 0 while reset = 1.
  - A symbol in flight or in the holding buffer is discarded; there is no partial output after reset.
- Accept: a symbol is taken on an edge where in_valid & in_ready. in_data is copied into the holding register and hold_full is set.
- in_ready = !reset & (!hold_full | load_now). It is derived from registers only and has no combinational path from in_valid.
- load_now is true when hold_full and the shifter is idle or outputting its last bit (counter = WIDTH-1).
- On a load_now edge:
  - The shifter takes the holding register; the counter resets to 0.
  - out_bit is set to the first bit (MSB if MSB_FIRST, else LSB); out_valid = 1, out_sof = 1.
  - hold_full is cleared unless a new symbol is accepted on the same edge, in which case it stays set with the new data.
- Streaming edges: out_bit takes the next bit, the counter increments, out_sof = 0. Each symbol occupies exactly WIDTH consecutive out_valid cycles.
- After the last bit, if no load_now:
  - out_valid = 0, out_bit = IDLE_VAL.
  - underrun = 1 for one cycle. It pulses only on a streaming-to-idle transition, never during idle after reset.
- Latency: accept edge N, then first bit registered at edge N+1 (shifter idle). With a back-to-back feed the throughput is 1 symbol per WIDTH cycles, without gaps.
- Holding buffer full and shifter mid-symbol: in_ready = 0 and in_data is ignored; the upstream block must hold it.
- Changes on in_data while in_valid = 0, or while in_ready = 0, have no effect. Restart happens only through the handshake.

Decomposition:
- Package pcie_phy_pkg:
  - SYM_W_8B10B = 10.
  - COMMA_K28_5_RDN = 10'h0FA and COMMA_K28_5_RDP = 10'h305.
  - Shared IDLE_VAL default.
- Sub-module serializer_shift_reg (WIDTH, MSB_FIRST): load/shift/counter/last-bit flag.
- The top level holds the holding buffer, handshake and output flags.

Test Plan:
1. WIDTH=10, MSB_FIRST=1. Single symbol 10'h0FA accepted at edge N -> out_bit 0,0,1,1,1,1,1,0,1,0 at edges N+1..N+10; out_sof only at N+1; out_valid 0 and underrun 1 at N+11; out_bit = IDLE_VAL afterwards.
2. in_valid held high with 10'h0FA then 10'h305 -> 20 contiguous out_valid cycles (0011111010 then 1100000101); out_sof at cycles 1 and 11; no underrun until cycle 21.
3. MSB_FIRST=0, symbol 10'h001 -> first out_bit = 1 followed by nine 0s.
4. Backpressure: second symbol accepted while first shifts, third offered -> in_ready = 0 until the edge where the counter = 9; third symbol is not lost and starts immediately after the second.
5. Reset asserted during bit 4 of a symbol with the holding buffer full -> next edge: out_valid = 0, out_bit = IDLE_VAL, in_ready = 0; after release, no residual bits and in_ready = 1.
6. in_data toggled with in_valid = 0 while idle -> out_valid stays 0 and no underrun pulse.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared constants for the PCIe PHY transmit path
package pcie_phy_pkg;

  // 8b10b symbol width and the two running-disparity forms of the K28.5 comma
  localparam int          SYM_W_8B10B      = 10;
  localparam logic [9:0]  COMMA_K28_5_RDN  = 10'h0FA;
  localparam logic [9:0]  COMMA_K28_5_RDP  = 10'h305;

  // Level held on the serial line between symbols
  localparam logic        IDLE_VAL_DEFAULT = 1'b0;

endpackage

// File: rtl/serializer_shift_reg.sv
// rtl/serializer_shift_reg.sv - symbol shift register with bit counter and last-bit flag
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load, load_data take a new symbol; its first bit appears on ser_bit next cycle
//   ser_bit         registered serial bit (IDLE_VAL when not active)
//   active          registered: ser_bit carries a symbol bit
//   last            ser_bit is the final bit of the current symbol
module serializer_shift_reg #(
  parameter int   WIDTH     = 10,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_VAL  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_bit,
  output logic             active,
  output logic             last
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  // Holds the bits not yet sent; the next bit to send always sits at the
  // outgoing end, so ser_bit is simply reloaded from that end each cycle.
  logic [WIDTH-1:0] rest;
  logic [CNT_W-1:0] cnt;

  assign last = active && (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      rest    <= '0;
      cnt     <= '0;
      active  <= 1'b0;
      ser_bit <= IDLE_VAL;
    end else if (load) begin
      ser_bit <= MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
      rest    <= MSB_FIRST ? {load_data[WIDTH-2:0], 1'b0} : {1'b0, load_data[WIDTH-1:1]};
      cnt     <= '0;
      active  <= 1'b1;
    end else if (active && !last) begin
      ser_bit <= MSB_FIRST ? rest[WIDTH-1] : rest[0];
      rest    <= MSB_FIRST ? {rest[WIDTH-2:0], 1'b0} : {1'b0, rest[WIDTH-1:1]};
      cnt     <= cnt + 1'b1;
    end else if (active) begin
      ser_bit <= IDLE_VAL;
      cnt     <= '0;
      active  <= 1'b0;
    end
  end

endmodule

// File: rtl/serializer_stream.sv
// rtl/serializer_stream.sv - parallel-to-serial stage with one-entry holding buffer
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_data, in_valid    symbol from the 8b10b encoder
//   in_ready             symbol accepted on edges where in_valid & in_ready
//   out_bit, out_valid   registered serial bit and its qualifier
//   out_sof              registered: out_bit is the first bit of a symbol
//   underrun             one-cycle pulse when streaming stops for lack of data
module serializer_stream
  import pcie_phy_pkg::*;
#(
  parameter int   WIDTH     = SYM_W_8B10B,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_VAL  = IDLE_VAL_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_sof,
  output logic             underrun
);

  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             sh_last;
  logic             load_now;
  logic             accept;

  // The shifter is free when idle or on its final bit, so the held symbol
  // follows the previous one with no gap.
  assign load_now = hold_full && (!out_valid || sh_last);
  assign in_ready = !reset && (!hold_full || load_now);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_data <= '0;
      hold_full <= 1'b0;
      out_sof   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (accept) begin
        hold_data <= in_data;
        hold_full <= 1'b1;
      end else if (load_now) begin
        hold_full <= 1'b0;
      end
      out_sof  <= load_now;
      // Final bit with nothing queued behind it: the line goes idle next cycle.
      underrun <= sh_last && !load_now;
    end
  end

  serializer_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .IDLE_VAL  (IDLE_VAL)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (load_now),
    .load_data (hold_data),
    .ser_bit   (out_bit),
    .active    (out_valid),
    .last      (sh_last)
  );

endmodule

// File: tb/tb_serializer_stream.sv
// tb/tb_serializer_stream.sv - self-checking bench for serializer_stream
module tb_serializer_stream;
  import pcie_phy_pkg::*;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;

  logic rdy_m, bit_m, val_m, sof_m, und_m;
  logic rdy_l, bit_l, val_l, sof_l, und_l;

  serializer_stream #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)) dut_m (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
    .out_bit(bit_m), .out_valid(val_m), .out_sof(sof_m), .underrun(und_m));

  serializer_stream #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_VAL(1'b1)) dut_l (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
    .out_bit(bit_l), .out_valid(val_l), .out_sof(sof_l), .underrun(und_l));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: every accepted symbol is placed on a timeline of edges. It starts
  // on the edge after acceptance, or right after the previous symbol ends.
  int           cyc = 0;
  int           last_start = -100;
  int           last_end = -100;
  logic [W-1:0] s_sym [0:2047];
  int           s_idx [0:2047];
  bit           s_v   [0:2047];
  bit           prev_v = 1'b0;
  bit           acc = 1'b0;

  logic [63:0] cap_m = '0;
  logic [63:0] cap_l = '0;
  int          n_val = 0;
  int          n_sof = 0;
  int          n_und = 0;

  // Ready for the coming edge unless a queued symbol starts after that edge.
  function automatic bit model_ready();
    return !reset && (last_start <= cyc + 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready_msb", 64'(rdy_m), 64'(model_ready()));
    chk("in_ready_lsb", 64'(rdy_l), 64'(model_ready()));
  end

  always @(posedge clk) begin
    int e, start;
    bit rdy, ev, es, eu, eb_m, eb_l;
    rdy = model_ready();
    e   = cyc + 1;
    acc = 1'b0;
    if (reset) begin
      for (int k = e; k < e + 40; k++) s_v[k] = 1'b0;
      last_start = -100;
      last_end   = -100;
    end else if (in_valid && rdy) begin
      start = (e + 1 > last_end + 1) ? e + 1 : last_end + 1;
      for (int k = 0; k < W; k++) begin
        s_v[start+k]   = 1'b1;
        s_sym[start+k] = in_data;
        s_idx[start+k] = k;
      end
      last_start = start;
      last_end   = start + W - 1;
      acc        = 1'b1;
    end
    cyc  = e;
    ev   = s_v[e];
    es   = ev && (s_idx[e] == 0);
    eu   = !reset && prev_v && !ev;
    eb_m = ev ? s_sym[e][W-1-s_idx[e]] : 1'b0;
    eb_l = ev ? s_sym[e][s_idx[e]]     : 1'b1;
    prev_v = ev;
    #1;
    chk("out_valid_msb", 64'(val_m), 64'(ev));
    chk("out_valid_lsb", 64'(val_l), 64'(ev));
    chk("out_sof_msb",   64'(sof_m), 64'(es));
    chk("out_sof_lsb",   64'(sof_l), 64'(es));
    chk("underrun_msb",  64'(und_m), 64'(eu));
    chk("underrun_lsb",  64'(und_l), 64'(eu));
    chk("out_bit_msb",   64'(bit_m), 64'(eb_m));
    chk("out_bit_lsb",   64'(bit_l), 64'(eb_l));
    if (val_m) cap_m = {cap_m[62:0], bit_m};
    if (val_l) cap_l = {cap_l[62:0], bit_l};
    n_val += int'(val_m);
    n_sof += int'(sof_m);
    n_und += int'(und_m);
  end

  task automatic clr();
    cap_m = '0; cap_l = '0; n_val = 0; n_sof = 0; n_und = 0;
  endtask

  task automatic send(input logic [W-1:0] d);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!acc && n < 100);
    chk("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    idle(3);

    // 1: single comma, MSB first and LSB first
    clr();
    send(COMMA_K28_5_RDN);
    idle(15);
    chk("t1_bits_msb", cap_m[9:0], 64'h0FA);
    chk("t1_bits_lsb", cap_l[9:0], 64'h17C);
    chk("t1_nval", 64'(n_val), 64'd10);
    chk("t1_nsof", 64'(n_sof), 64'd1);
    chk("t1_nund", 64'(n_und), 64'd1);

    // 2: two symbols back-to-back
    clr();
    send(COMMA_K28_5_RDN);
    send(COMMA_K28_5_RDP);
    idle(25);
    chk("t2_bits", cap_m[19:0], 64'h3EB05);
    chk("t2_nval", 64'(n_val), 64'd20);
    chk("t2_nsof", 64'(n_sof), 64'd2);
    chk("t2_nund", 64'(n_und), 64'd1);

    // 3: LSB-first ordering of 10'h001
    clr();
    send(10'h001);
    idle(15);
    chk("t3_bits_lsb", cap_l[9:0], 64'h200);
    chk("t3_bits_msb", cap_m[9:0], 64'h001);

    // 4: backpressure with three queued symbols
    clr();
    send(10'h0FA);
    send(10'h305);
    send(10'h155);
    idle(40);
    chk("t4_bits", cap_m[29:0], {34'd0, 10'h0FA, 10'h305, 10'h155});
    chk("t4_nval", 64'(n_val), 64'd30);
    chk("t4_nund", 64'(n_und), 64'd1);

    // 5: reset mid-symbol with the holding buffer full
    clr();
    send(10'h0FA);
    send(10'h305);
    idle(3);
    reset = 1'b1;
    @(posedge clk); #2;
    chk("t5_valid", 64'(val_m), 64'd0);
    chk("t5_idle_bit", 64'(bit_m), 64'd0);
    chk("t5_ready", 64'(rdy_m), 64'd0);
    reset = 1'b0;
    clr();
    idle(30);
    chk("t5_nval", 64'(n_val), 64'd0);
    chk("t5_nund", 64'(n_und), 64'd0);
    chk("t5_ready_after", 64'(rdy_m), 64'd1);

    // 6: data toggling without valid while idle
    clr();
    repeat (20) begin
      in_data = W'($urandom);
      @(posedge clk); #2;
    end
    chk("t6_nval", 64'(n_val), 64'd0);
    chk("t6_nund", 64'(n_und), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
